// File: rtl/cfg_capture_seq.sv
// Config pin capture sequencer: synchronises cfg_in, waits for it to settle, latches it,
// releases core_rst, and supports runtime re-capture through a req/ack handshake.
module cfg_capture_seq #(
  parameter int WIDTH         = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] cfg_in,
  input  logic             relatch_req,
  output logic             relatch_ack,
  output logic [WIDTH-1:0] latched,
  output logic             latched_valid,
  output logic             core_rst,
  output logic             changed,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    SETTLE   = 2'd0,
    RUN      = 2'd1,
    RESETTLE = 2'd2,
    ACKWAIT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_step;
  logic [WIDTH-1:0] latched_d;
  logic             valid_d, core_rst_d, ack_d, changed_d;
  logic [WIDTH-1:0] s;
  logic             stable, capture;

  assign s        = sync_q[SYNC_STAGES-1];
  assign stable   = (s == prev_q) && ena;
  assign capture  = stable && (cnt_q == CNT_LAST);
  assign cnt_step = !stable ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));

  // Handshake: relatch_req is a level; one capture is taken per assertion seen in RUN,
  // relatch_ack pulses for one cycle when latched is rewritten, and the sequencer waits
  // in ACKWAIT for relatch_req to drop before another request is accepted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latched_d  = latched;
    valid_d    = latched_valid;
    core_rst_d = core_rst;
    ack_d      = 1'b0;
    changed_d  = 1'b0;
    unique case (state_q)
      SETTLE: begin
        cnt_d      = cnt_step;
        core_rst_d = 1'b1;
        if (capture) begin
          latched_d = s;
          valid_d   = 1'b1;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        core_rst_d = 1'b0;
        if (relatch_req) begin
          cnt_d   = '0;
          state_d = RESETTLE;
        end
      end
      RESETTLE: begin
        cnt_d = cnt_step;
        if (capture) begin
          latched_d = s;
          ack_d     = 1'b1;
          changed_d = (s != latched);
          cnt_d     = '0;
          state_d   = ACKWAIT;
        end
      end
      ACKWAIT: begin
        if (!relatch_req) state_d = RUN;
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      state_q       <= SETTLE;
      latched       <= '0;
      latched_valid <= 1'b0;
      core_rst      <= 1'b1;
      relatch_ack   <= 1'b0;
      changed       <= 1'b0;
    end else begin
      sync_q[0] <= cfg_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q        <= s;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      latched       <= latched_d;
      latched_valid <= valid_d;
      core_rst      <= core_rst_d;
      relatch_ack   <= ack_d;
      changed       <= changed_d;
    end
  end

  assign fsm_state = state_q;

endmodule
